// File: rtl/pdp8_pkg.sv
// PDP-8 IFD shared definitions.
// Widths, reset vector and fetch FSM state type.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int DATA_WIDTH = `DATA_WIDTH;

  localparam logic [11:0] START_ADDR_DEF = 12'o0200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CAPT  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// PDP-8 instruction fetch control stage.
// Owns the PC, issues reads, hands words to decode.
module ifu_fetch_ctrl
  import pdp8_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter logic [ADDR_W-1:0] START_ADDR =
    ADDR_W'(START_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ifu_rd_req,
  output logic [ADDR_W-1:0] ifu_rd_addr,
  input  logic [DATA_W-1:0] ifu_rd_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              exec_pc_load,
  input  logic [ADDR_W-1:0] exec_pc_val,
  input  logic              exec_halt
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] w_pc_inc;

  // Next sequential PC, wraps at the top of memory.
  assign w_pc_inc = r_pc + ADDR_W'(1);

  assign ifu_rd_req  = r_req;
  assign ifu_rd_addr = r_addr;
  assign if_valid    = r_valid;
  assign if_instr    = r_instr;
  assign if_pc       = r_if_pc;

  // Fetch FSM: redirect wins over any state, outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= START_ADDR;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_if_pc <= '0;
    end else if (exec_pc_load) begin
      r_pc    <= exec_pc_val;
      r_valid <= 1'b0;
      if (exec_halt) begin
        r_state <= IDLE;
        r_req   <= 1'b0;
      end else begin
        r_state <= REQ;
        r_req   <= 1'b1;
        r_addr  <= exec_pc_val;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!exec_halt) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        REQ: begin
          r_state <= CAPT;
          r_req   <= 1'b0;
        end
        CAPT: begin
          r_state <= VALID;
          r_instr <= ifu_rd_data;
          r_if_pc <= r_pc;
          r_valid <= 1'b1;
        end
        VALID: begin
          if (id_ready) begin
            r_pc    <= w_pc_inc;
            r_valid <= 1'b0;
            if (exec_halt) begin
              r_state <= IDLE;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_addr  <= w_pc_inc;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for the PDP-8 fetch control stage.
// Directed scenarios, then randomized traffic vs a PC model.
module tb_ifu_fetch_ctrl;
  import pdp8_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        if_valid;
  logic [11:0] if_instr;
  logic [11:0] if_pc;
  logic        id_ready;
  logic        exec_pc_load;
  logic [11:0] exec_pc_val;
  logic        exec_halt;

  logic [11:0] mem [4096];
  logic [3:0]  seen;

  int n_chk  = 0;
  int n_fail = 0;

  ifu_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ifu_rd_req   (ifu_rd_req),
    .ifu_rd_addr  (ifu_rd_addr),
    .ifu_rd_data  (ifu_rd_data),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .id_ready     (id_ready),
    .exec_pc_load (exec_pc_load),
    .exec_pc_val  (exec_pc_val),
    .exec_halt    (exec_halt)
  );

  always #5 clk = ~clk;

  // Memory BFM: registered read, data valid the cycle after req.
  always @(posedge clk) begin
    if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];
  end

  // Record which fetch states get exercised.
  always @(posedge clk) begin
    if (reset) seen <= '0;
    else seen[dut.r_state] <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    logic [11:0] exp_pc;
    logic        pv;
    logic [11:0] ppc;
    logic [11:0] pins;
    logic        rdy;
    logic        ld;
    logic [11:0] lval;
    int          accepted;

    for (int i = 0; i < 4096; i++)
      mem[i] = 12'($urandom);
    ifu_rd_data  = '0;
    reset        = 1'b1;
    id_ready     = 1'b1;
    exec_pc_load = 1'b0;
    exec_pc_val  = '0;
    exec_halt    = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req",   32'(ifu_rd_req), 0);
    chk("rst_addr",  32'(ifu_rd_addr), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_instr", 32'(if_instr), 0);
    chk("rst_pc",    32'(if_pc), 0);
    reset = 1'b0;

    // 1. Reset release, 3-cycle cadence
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_req",  32'(ifu_rd_req), 1);
      chk("t1_addr", 32'(ifu_rd_addr), 32'(12'o0200 + k));
      chk("t1_nv",   32'(if_valid), 0);
      if (k == 2) id_ready = 1'b0;
      tick();
      chk("t1_capt", 32'(if_valid), 0);
      tick();
      chk("t1_valid", 32'(if_valid), 1);
      chk("t1_pc",    32'(if_pc), 32'(12'o0200 + k));
      chk("t1_instr", 32'(if_instr),
          32'(mem[12'o0200 + k]));
    end

    // 2. Backpressure: hold for 5 cycles
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_valid", 32'(if_valid), 1);
      chk("t2_pc",    32'(if_pc), 32'(12'o0202));
      chk("t2_instr", 32'(if_instr), 32'(mem[12'o0202]));
      chk("t2_noreq", 32'(ifu_rd_req), 0);
    end
    id_ready = 1'b1;
    tick();
    chk("t2_req",  32'(ifu_rd_req), 1);
    chk("t2_addr", 32'(ifu_rd_addr), 32'(12'o0203));

    // 3. Redirect during CAPT of 0203
    tick();
    chk("t3_capt", 32'(ifu_rd_req), 0);
    exec_pc_load = 1'b1;
    exec_pc_val  = 12'o4000;
    id_ready     = 1'b0;
    tick();
    exec_pc_load = 1'b0;
    chk("t3_nv",   32'(if_valid), 0);
    chk("t3_req",  32'(ifu_rd_req), 1);
    chk("t3_addr", 32'(ifu_rd_addr), 32'(12'o4000));
    tick();
    chk("t3_nv2",  32'(if_valid), 0);
    tick();
    chk("t3_valid", 32'(if_valid), 1);
    chk("t3_pc",    32'(if_pc), 32'(12'o4000));
    chk("t3_instr", 32'(if_instr), 32'(mem[12'o4000]));

    // 4. Redirect together with acceptance
    exec_pc_load = 1'b1;
    exec_pc_val  = 12'o0010;
    id_ready     = 1'b1;
    tick();
    exec_pc_load = 1'b0;
    chk("t4_req",  32'(ifu_rd_req), 1);
    chk("t4_addr", 32'(ifu_rd_addr), 32'(12'o0010));
    chk("t4_nv",   32'(if_valid), 0);
    tick(); tick();
    chk("t4_pc",   32'(if_pc), 32'(12'o0010));
    tick();
    chk("t4_next", 32'(ifu_rd_addr), 32'(12'o0011));

    // 5. Wrap-around from 7777 (redirect while in REQ)
    exec_pc_load = 1'b1;
    exec_pc_val  = 12'o7777;
    tick();
    exec_pc_load = 1'b0;
    chk("t5_addr", 32'(ifu_rd_addr), 32'(12'o7777));
    tick(); tick();
    chk("t5_pc",    32'(if_pc), 32'(12'o7777));
    chk("t5_instr", 32'(if_instr), 32'(mem[12'o7777]));
    tick();
    chk("t5_req",  32'(ifu_rd_req), 1);
    chk("t5_wrap", 32'(ifu_rd_addr), 0);

    // 6. Halt during REQ, then reset in CAPT
    exec_halt = 1'b1;
    tick();
    chk("t6_capt", 32'(if_valid), 0);
    tick();
    chk("t6_valid", 32'(if_valid), 1);
    chk("t6_pc",    32'(if_pc), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_idle", 32'(ifu_rd_req), 0);
      chk("t6_nv",   32'(if_valid), 0);
    end
    exec_halt = 1'b0;
    tick();
    chk("t6_req",  32'(ifu_rd_req), 1);
    chk("t6_addr", 32'(ifu_rd_addr), 32'(12'o0001));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rv",   32'(if_valid), 0);
    chk("t6_rreq", 32'(ifu_rd_req), 0);
    tick();
    chk("t6_rst_req",  32'(ifu_rd_req), 1);
    chk("t6_rst_addr", 32'(ifu_rd_addr), 32'(12'o0200));
    tick(); tick();
    chk("t6_rst_pc",   32'(if_pc), 32'(12'o0200));
    chk("t6_rst_instr", 32'(if_instr), 32'(mem[12'o0200]));

    // 7. Random traffic vs transaction-level PC model
    exp_pc   = 12'o0200;
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy  = ($urandom_range(9) < 7);
      ld   = ($urandom_range(19) == 0);
      lval = 12'($urandom);
      id_ready     = rdy;
      exec_pc_load = ld;
      exec_pc_val  = lval;
      exec_halt    = ($urandom_range(9) < 2);
      pv   = if_valid;
      ppc  = if_pc;
      pins = if_instr;
      tick();
      if (ld) begin
        exp_pc = lval;
      end else if (pv && rdy) begin
        exp_pc = exp_pc + 12'd1;
        accepted++;
      end
      if (ifu_rd_req)
        chk("r_addr", 32'(ifu_rd_addr), 32'(exp_pc));
      if (ifu_rd_req)
        chk("r_excl", 32'(if_valid), 0);
      if (pv && !rdy && !ld) begin
        chk("r_hold_v", 32'(if_valid), 1);
        chk("r_hold_pc", 32'(if_pc), 32'(ppc));
        chk("r_hold_in", 32'(if_instr), 32'(pins));
      end
      if (if_valid) begin
        chk("r_pc",    32'(if_pc), 32'(exp_pc));
        chk("r_instr", 32'(if_instr), 32'(mem[exp_pc]));
      end
    end
    chk("r_progress", 32'(accepted > 100), 1);
    chk("r_states", 32'(seen), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
